// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI-Lite memory slave and anything that talks to it.
// Holds the response codes, the default bus geometry and the channel state
// encodings, plus a helper that sizes a word index for a given storage depth.
package axi_lite_pkg;

    localparam int unsigned AXI_DATA_WIDTH = 32;
    localparam int unsigned AXI_ADDR_WIDTH = 8;
    localparam int unsigned AXI_RESP_WIDTH = 3;
    localparam int unsigned AXI_DEPTH      = 16;

    localparam int unsigned RESP_OKAY   = 0;
    localparam int unsigned RESP_SLVERR = 2;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

    // A one-word store still needs a one-bit index to form a legal port.
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/axi_lite_regfile.sv
// Word-organised storage behind the AXI-Lite slave.
// Ports:
//   clk, rst_n   - clock and asynchronous active-low reset (clears every word)
//   we           - write enable for one word this cycle
//   waddr        - word index to write
//   wstrb        - byte enables, bit i enables byte i of wdata
//   wdata        - write data
//   raddr        - word index to read
//   rdata        - combinational read of the current stored word
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = AXI_DATA_WIDTH,
    parameter int unsigned DEPTH      = AXI_DEPTH,
    parameter int unsigned IDX_WIDTH  = idx_width(AXI_DEPTH),
    parameter int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [IDX_WIDTH-1:0]  waddr,
    input  logic [STRB_WIDTH-1:0] wstrb,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IDX_WIDTH-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    // Only the enabled bytes of the addressed word change; the rest hold.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            for (int b = 0; b < int'(STRB_WIDTH); b++) begin
                if (wstrb[b]) begin
                    mem_d[waddr][8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Reading the registered array means a read sampled on the same edge as
    // a write sees the value from before that write.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI-Lite slave exposing a small word-addressed memory.
// Ports:
//   s_axi_aclk, s_axi_aresetn            - clock, asynchronous active-low reset
//   s_axi_aw*, s_axi_w*, s_axi_b*         - write address, data and response channels
//   s_axi_ar*, s_axi_r*                   - read address and data channels
// Word index is addr[ADDR_WIDTH-1:2]; indices at or beyond DEPTH answer SLVERR,
// leave memory untouched and read as zero. Read and write run independently.
module axi_lite_mem_slave
    import axi_lite_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = AXI_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = AXI_ADDR_WIDTH,
    parameter int unsigned RESP_WIDTH = AXI_RESP_WIDTH,
    parameter int unsigned DEPTH      = AXI_DEPTH
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8:0]   s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [RESP_WIDTH-1:0]   s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [RESP_WIDTH-1:0]   s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned IDX_WIDTH  = idx_width(DEPTH);

    // Write channel state
    w_state_e              w_state_q, w_state_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  aw_latched_q, aw_latched_d;
    logic                  w_latched_q, w_latched_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                  bvalid_q, bvalid_d;
    logic [RESP_WIDTH-1:0] bresp_q, bresp_d;

    // Read channel state
    r_state_e              r_state_q, r_state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [RESP_WIDTH-1:0] rresp_q, rresp_d;

    logic                  aw_hs, w_hs, ar_hs;
    logic [ADDR_WIDTH-1:0] eff_awaddr;
    logic [DATA_WIDTH-1:0] eff_wdata;
    logic [STRB_WIDTH-1:0] eff_wstrb;
    logic [ADDR_WIDTH-3:0] aw_idx, ar_idx;
    logic                  aw_in_range, ar_in_range;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  unused_bits;

    assign aw_hs = s_axi_awvalid & awready_q;
    assign w_hs  = s_axi_wvalid & wready_q;
    assign ar_hs = s_axi_arvalid & arready_q;

    // A beat arriving this cycle counts as latched, so a commit can happen on
    // the very edge the second half of the pair handshakes.
    assign eff_awaddr  = aw_latched_q ? awaddr_q : s_axi_awaddr;
    assign eff_wdata   = w_latched_q ? wdata_q : s_axi_wdata;
    assign eff_wstrb   = w_latched_q ? wstrb_q : s_axi_wstrb[STRB_WIDTH-1:0];
    assign aw_idx      = eff_awaddr[ADDR_WIDTH-1:2];
    assign ar_idx      = s_axi_araddr[ADDR_WIDTH-1:2];
    assign aw_in_range = 32'(aw_idx) < 32'(DEPTH);
    assign ar_in_range = 32'(ar_idx) < 32'(DEPTH);

    assign unused_bits = ^{eff_awaddr[1:0], s_axi_araddr[1:0], s_axi_wstrb[STRB_WIDTH]};

    // Write FSM: gather one AW and one W beat in any order, commit, respond.
    always_comb begin
        w_state_d    = w_state_q;
        awready_d    = awready_q;
        wready_d     = wready_q;
        aw_latched_d = aw_latched_q;
        w_latched_d  = w_latched_q;
        awaddr_d     = awaddr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        bvalid_d     = bvalid_q;
        bresp_d      = bresp_q;
        mem_we       = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_latched_d = 1'b1;
                    awaddr_d     = s_axi_awaddr;
                end
                if (w_hs) begin
                    w_latched_d = 1'b1;
                    wdata_d     = s_axi_wdata;
                    wstrb_d     = s_axi_wstrb[STRB_WIDTH-1:0];
                end
                awready_d = ~aw_latched_d;
                wready_d  = ~w_latched_d;
                if (aw_latched_d && w_latched_d) begin
                    mem_we    = aw_in_range;
                    bresp_d   = aw_in_range ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_SLVERR);
                    bvalid_d  = 1'b1;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    bvalid_d     = 1'b0;
                    aw_latched_d = 1'b0;
                    w_latched_d  = 1'b0;
                    awready_d    = 1'b1;
                    wready_d     = 1'b1;
                    w_state_d    = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            w_state_q    <= W_IDLE;
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            aw_latched_q <= 1'b0;
            w_latched_q  <= 1'b0;
            awaddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            bvalid_q     <= 1'b0;
            bresp_q      <= '0;
        end else begin
            w_state_q    <= w_state_d;
            awready_q    <= awready_d;
            wready_q     <= wready_d;
            aw_latched_q <= aw_latched_d;
            w_latched_q  <= w_latched_d;
            awaddr_q     <= awaddr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            bvalid_q     <= bvalid_d;
            bresp_q      <= bresp_d;
        end
    end

    // Read FSM: capture the addressed word on the AR handshake and hold it
    // until the master takes it.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    rdata_d   = ar_in_range ? mem_rdata : '0;
                    rresp_d   = ar_in_range ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_SLVERR);
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    axi_lite_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_WIDTH  (IDX_WIDTH),
        .STRB_WIDTH (STRB_WIDTH)
    ) u_regfile (
        .clk   (s_axi_aclk),
        .rst_n (s_axi_aresetn),
        .we    (mem_we),
        .waddr (aw_idx[IDX_WIDTH-1:0]),
        .wstrb (eff_wstrb),
        .wdata (eff_wdata),
        .raddr (ar_idx[IDX_WIDTH-1:0]),
        .rdata (mem_rdata)
    );

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Self-checking bench for axi_lite_mem_slave with default parameters.
// Stimulus tasks push expected B/R responses into queues; a monitor pops
// and compares them whenever a response handshake is about to happen.
module tb_axi_lite_mem_slave;

    logic        clk;
    logic        rst_n;
    logic [7:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [4:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [2:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [7:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [2:0]  rresp;
    logic        rvalid;
    logic        rready;

    typedef struct {
        logic [2:0]  resp;
        logic [31:0] data;
    } exp_t;

    exp_t bq[$];
    exp_t rq[$];
    exp_t exp_b;
    exp_t exp_r;

    int checks = 0;
    int errors = 0;

    axi_lite_mem_slave dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor: on the falling edge before a B or R handshake edge,
    // pop the oldest expected response and compare it with what is presented.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bvalid && bready) begin
                if (bq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL b_unexpected: got bresp 0x%0h with no response pending", bresp);
                end else begin
                    exp_b = bq.pop_front();
                    checkOutput("bresp", 64'(bresp), 64'(exp_b.resp));
                end
            end
            if (rvalid && rready) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL r_unexpected: got rdata 0x%0h with no response pending", rdata);
                end else begin
                    exp_r = rq.pop_front();
                    checkOutput("rdata", 64'(rdata), 64'(exp_r.data));
                    checkOutput("rresp", 64'(rresp), 64'(exp_r.resp));
                end
            end
        end
    end

    // Full write with AW and W offered together; bready is held low for
    // 'hold' cycles after bvalid rises, checking the response stays put.
    task automatic applyStimulus(input logic [7:0] addr, input logic [31:0] data,
                                 input logic [4:0] strb, input logic [2:0] resp, input int hold);
        exp_t item;
        logic got;
        item.resp = resp;
        item.data = 32'h0;
        bq.push_back(item);
        bready  = (hold == 0);
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = awready && wready;
            @(posedge clk);
            #1;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        checkOutput("aw_w_handshake", 64'(got), 64'd1);
        @(negedge clk);
        checkOutput("b_latency", 64'(bvalid), 64'd1);
        for (int i = 0; i < hold; i++) begin
            checkOutput("b_hold_valid", 64'(bvalid), 64'd1);
            checkOutput("b_hold_resp", 64'(bresp), 64'(resp));
            checkOutput("b_hold_readies", 64'({awready, wready}), 64'd0);
            @(posedge clk);
            #1;
            if (i == hold - 1) bready = 1'b1;
            @(negedge clk);
        end
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(posedge clk);
            #1;
            got = !bvalid;
        end
        checkOutput("b_complete", 64'(got), 64'd1);
        checkOutput("b_readies_return", 64'({awready, wready}), 64'd3);
    endtask

    // Single read; rready is held low for 'hold' cycles after rvalid rises.
    task automatic doRead(input logic [7:0] addr, input logic [31:0] data,
                          input logic [2:0] resp, input int hold);
        exp_t item;
        logic got;
        item.resp = resp;
        item.data = data;
        rq.push_back(item);
        rready  = (hold == 0);
        araddr  = addr;
        arvalid = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = arready;
            @(posedge clk);
            #1;
        end
        arvalid = 1'b0;
        checkOutput("ar_handshake", 64'(got), 64'd1);
        @(negedge clk);
        checkOutput("r_latency", 64'(rvalid), 64'd1);
        for (int i = 0; i < hold; i++) begin
            checkOutput("r_hold_valid", 64'(rvalid), 64'd1);
            checkOutput("r_hold_data", 64'(rdata), 64'(data));
            checkOutput("r_hold_resp", 64'(rresp), 64'(resp));
            @(posedge clk);
            #1;
            if (i == hold - 1) rready = 1'b1;
            @(negedge clk);
        end
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(posedge clk);
            #1;
            got = !rvalid;
        end
        checkOutput("r_complete", 64'(got), 64'd1);
        checkOutput("r_arready_return", 64'(arready), 64'd1);
    endtask

    // Reset release: readies must stay low until the first clock edge.
    task automatic releaseReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("readies_low_before_edge", 64'({awready, wready, arready}), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("readies_first_edge", 64'({awready, wready, arready}), 64'd7);
    endtask

    // Hard stop if something wedges beyond every bounded wait.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenario sequence.
    initial begin
        logic got;
        exp_t item;
        rst_n   = 1'b0;
        awaddr  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wvalid  = 1'b0;
        bready  = 1'b1;
        araddr  = '0;
        arvalid = 1'b0;
        rready  = 1'b1;
        #1;
        checkOutput("reset_outputs", 64'({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata}), 64'd0);
        repeat (3) @(posedge clk);
        releaseReset();

        // Same-cycle AW/W write, then read back.
        applyStimulus(8'h00, 32'h0000_0038, 5'h0F, 3'd0, 0);
        doRead(8'h00, 32'h0000_0038, 3'd0, 0);

        // W three cycles ahead of AW.
        bready = 1'b1;
        wdata  = 32'hAABB_CCDD;
        wstrb  = 5'h0F;
        wvalid = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = wready;
            @(posedge clk);
            #1;
        end
        wvalid = 1'b0;
        checkOutput("w_first_handshake", 64'(got), 64'd1);
        item.resp = 3'd0;
        item.data = 32'h0;
        bq.push_back(item);
        @(negedge clk);
        checkOutput("w_first_wready_low", 64'(wready), 64'd0);
        checkOutput("w_first_awready_high", 64'(awready), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("w_first_wready_still_low", 64'(wready), 64'd0);
        @(posedge clk);
        #1;
        awaddr  = 8'h04;
        awvalid = 1'b1;
        @(negedge clk);
        checkOutput("w_first_b_not_early", 64'(bvalid), 64'd0);
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        @(negedge clk);
        checkOutput("w_first_b_latency", 64'(bvalid), 64'd1);
        @(posedge clk);
        #1;
        checkOutput("w_first_b_done", 64'(bvalid), 64'd0);
        checkOutput("w_first_readies_return", 64'({awready, wready}), 64'd3);

        // Partial strobe; strobe MSB set but must be ignored.
        applyStimulus(8'h04, 32'h0000_1100, 5'h12, 3'd0, 0);
        doRead(8'h04, 32'hAABB_11DD, 3'd0, 0);

        // Zero strobe completes OKAY without touching memory; low address bits ignored.
        applyStimulus(8'h06, 32'hFFFF_FFFF, 5'h00, 3'd0, 0);
        doRead(8'h07, 32'hAABB_11DD, 3'd0, 0);

        // Out-of-range write and read; word 0 must not alias.
        applyStimulus(8'h40, 32'hDEAD_BEEF, 5'h0F, 3'd2, 0);
        doRead(8'h40, 32'h0, 3'd2, 0);
        doRead(8'h00, 32'h0000_0038, 3'd0, 0);
        doRead(8'hFC, 32'h0, 3'd2, 0);

        // Last in-range word.
        applyStimulus(8'h3C, 32'hCAFE_F00D, 5'h0F, 3'd0, 0);
        doRead(8'h3C, 32'hCAFE_F00D, 3'd0, 0);

        // Back-pressure on both response channels.
        applyStimulus(8'h08, 32'h1234_5678, 5'h0F, 3'd0, 5);
        doRead(8'h08, 32'h1234_5678, 3'd0, 4);

        // Read accepted on the same edge as a write commit sees the old data.
        fork
            applyStimulus(8'h08, 32'h0BAD_F00D, 5'h0F, 3'd0, 0);
            doRead(8'h08, 32'h1234_5678, 3'd0, 0);
        join
        doRead(8'h08, 32'h0BAD_F00D, 3'd0, 0);

        // Reset while a write response is pending.
        bready  = 1'b0;
        awaddr  = 8'h0C;
        wdata   = 32'h55AA_55AA;
        wstrb   = 5'h0F;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        @(negedge clk);
        checkOutput("pre_reset_bvalid", 64'(bvalid), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_async_outputs", 64'({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata}), 64'd0);
        releaseReset();
        bready = 1'b1;
        doRead(8'h0C, 32'h0, 3'd0, 0);
        doRead(8'h00, 32'h0, 3'd0, 0);
        doRead(8'h04, 32'h0, 3'd0, 0);

        repeat (3) @(posedge clk);
        checkOutput("b_queue_drained", 64'(bq.size()), 64'd0);
        checkOutput("r_queue_drained", 64'(rq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
